// File: rtl/mul_host_uart_initiator.sv
// Host-side end of the multiplier UART link: sends the operand pair as byte
// frames, then collects the product frames and presents the assembled product.
module mul_host_uart_initiator #(
  parameter int N              = 16,
  parameter int RESULT_BYTES   = 2,
  parameter int GAP_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              op_ba,
  input  logic                      start,
  output logic                      busy,
  output logic                      uart_tx_start,
  output logic [7:0]                uart_transmit_data,
  input  logic                      uart_tx_ready,
  input  logic [7:0]                uart_received_data,
  input  logic                      uart_rx_valid,
  output logic [8*RESULT_BYTES-1:0] result,
  output logic                      result_valid,
  output logic                      timeout_err
);

  localparam int TX_FRAMES = N / 8;
  localparam int MAXF      = (TX_FRAMES > RESULT_BYTES) ? TX_FRAMES : RESULT_BYTES;
  localparam int FW        = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam int GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [FW-1:0] TX_LAST  = FW'(TX_FRAMES - 1);
  localparam logic [FW-1:0] RX_LAST  = FW'(RESULT_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_REQ, S_TX_ACK, S_TX_DONE, S_TX_GAP, S_RX_WAIT, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [FW-1:0]             frame_q, frame_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [N-1:0]              shadow_q, shadow_d;
  logic                      rx_q;
  logic                      tx_start_q, tx_start_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic [8*RESULT_BYTES-1:0] result_q, result_d;
  logic                      rvalid_q, rvalid_d;
  logic                      tmo_err_q, tmo_err_d;
  logic                      rx_rise;

  // A level already high when sampled never counts as a fresh byte.
  assign rx_rise = uart_rx_valid & ~rx_q;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    shadow_d   = shadow_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    result_d   = result_q;
    rvalid_d   = 1'b0;
    tmo_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = op_ba;
          frame_d  = '0;
          state_d  = S_TX_REQ;
        end
      end
      S_TX_REQ: begin
        if (uart_tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = shadow_q[{frame_q, 3'b000} +: 8];
          state_d    = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (!uart_tx_ready) begin
          tx_start_d = 1'b0;
          state_d    = S_TX_DONE;
        end
      end
      S_TX_DONE: begin
        if (uart_tx_ready) begin
          gap_d   = '0;
          state_d = S_TX_GAP;
        end
      end
      S_TX_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (frame_q == TX_LAST) begin
            frame_d = '0;
            tmo_d   = '0;
            state_d = S_RX_WAIT;
          end else begin
            frame_d = frame_q + 1'b1;
            state_d = S_TX_REQ;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RX_WAIT: begin
        // A byte arriving on the terminal count wins over the timeout.
        if (rx_rise) begin
          result_d[{frame_q, 3'b000} +: 8] = uart_received_data;
          tmo_d = '0;
          if (frame_q == RX_LAST) begin
            state_d = S_DONE;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      rx_q       <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      result_q   <= '0;
      rvalid_q   <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      rx_q       <= uart_rx_valid;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      result_q   <= result_d;
      rvalid_q   <= rvalid_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign busy               = (state_q != S_IDLE);
  assign uart_tx_start      = tx_start_q;
  assign uart_transmit_data = tx_data_q;
  assign result             = result_q;
  assign result_valid       = rvalid_q;
  assign timeout_err        = tmo_err_q;

endmodule

// File: tb/tb_mul_host_uart_initiator.sv
// Bench for mul_host_uart_initiator: UART transmitter model plus scoreboard of
// expected frames and products.
module tb_mul_host_uart_initiator;
  localparam int GAP = 100;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] op_ba;
  logic        start;
  logic        busy;
  logic        uart_tx_start;
  logic [7:0]  uart_transmit_data;
  logic        uart_tx_ready;
  logic [7:0]  uart_received_data;
  logic        uart_rx_valid;
  logic [15:0] result;
  logic        result_valid;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit hold_low   = 1'b0;
  bit stable_err = 1'b0;

  logic [7:0]  tx_bytes[$];
  int          tx_cycles[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_res[$];

  mul_host_uart_initiator #(
    .N(16), .RESULT_BYTES(2), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .op_ba(op_ba), .start(start), .busy(busy),
    .uart_tx_start(uart_tx_start), .uart_transmit_data(uart_transmit_data),
    .uart_tx_ready(uart_tx_ready), .uart_received_data(uart_received_data),
    .uart_rx_valid(uart_rx_valid), .result(result), .result_valid(result_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART transmitter model: holds off acceptance for three cycles, then drops ready.
  initial begin
    logic [7:0] md;
    bit         mab;
    uart_tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_low) begin
        uart_tx_ready = 1'b0;
      end else if (uart_tx_start && uart_tx_ready) begin
        md  = uart_transmit_data;
        mab = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (!uart_tx_start) begin
            mab = 1'b1;
            break;
          end
          if (uart_transmit_data !== md) stable_err = 1'b1;
        end
        if (!mab) begin
          uart_tx_ready = 1'b0;
          tx_bytes.push_back(md);
          tx_cycles.push_back(cyc);
          repeat (5) @(negedge clk);
          uart_tx_ready = 1'b1;
        end
      end else begin
        uart_tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [15:0] op);
    @(negedge clk);
    op_ba = op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    uart_received_data = b;
    uart_rx_valid      = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_bytes.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op_ba = '0;
    uart_rx_valid = 1'b0; uart_received_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (uart_tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", uart_tx_start); end
    n_checks++; if (uart_transmit_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", uart_transmit_data); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    logic [7:0] eb, gb;
    logic [15:0] er;
    tx_bytes.delete(); tx_cycles.delete();
    exp_tx.push_back(8'h0C); exp_tx.push_back(8'h0B);
    exp_res.push_back(16'h0084);
    do_start(16'h0B0C);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++; if ({uart_tx_start, uart_transmit_data} !== {1'b1, 8'h0C}) begin
      n_fail++; $display("FAIL basic_first_tx: got start=%b data=%h expected start=1 data=0c", uart_tx_start, uart_transmit_data); end
    wait_tx(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_tx_count: got %0d frames expected 2", tx_bytes.size()); end
    if (tx_cycles.size() >= 2) begin
      n_checks++; if (tx_cycles[1] - tx_cycles[0] <= GAP) begin
        n_fail++; $display("FAIL basic_gap: got %0d cycles expected more than %0d", tx_cycles[1] - tx_cycles[0], GAP); end
    end
    while (exp_tx.size() > 0) begin
      eb = exp_tx.pop_front();
      gb = (tx_bytes.size() > 0) ? tx_bytes.pop_front() : 8'hxx;
      n_checks++; if (gb !== eb) begin n_fail++; $display("FAIL basic_frame: got %h expected %h", gb, eb); end
    end
    repeat (120) @(negedge clk);
    send_rx(8'h84);
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", result_valid); end
    send_rx(8'h00);
    er = exp_res.pop_front();
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_result_valid: got %b expected 1", result_valid); end
    n_checks++; if (result !== er) begin n_fail++; $display("FAIL basic_result: got %h expected %h", result, er); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    @(negedge clk);
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: got %b expected 0", result_valid); end
  endtask

  task automatic test_ready_low;
    bit ok, bad;
    logic [7:0] eb, gb;
    logic [15:0] er;
    tx_bytes.delete(); tx_cycles.delete();
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h34);
    exp_res.push_back(16'h2211);
    stable_err = 1'b0;
    hold_low = 1'b1;
    @(negedge clk);
    do_start(16'h3456);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_tx_start !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL ready_low_no_start: got 1 expected 0"); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ready_low_busy: got %b expected 1", busy); end
    hold_low = 1'b0;
    wait_tx(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ready_low_tx_count: got %0d frames expected 2", tx_bytes.size()); end
    while (exp_tx.size() > 0) begin
      eb = exp_tx.pop_front();
      gb = (tx_bytes.size() > 0) ? tx_bytes.pop_front() : 8'hxx;
      n_checks++; if (gb !== eb) begin n_fail++; $display("FAIL ready_low_frame: got %h expected %h", gb, eb); end
    end
    n_checks++; if (stable_err) begin n_fail++; $display("FAIL ready_low_data_stable: got unstable expected stable"); end
    repeat (120) @(negedge clk);
    send_rx(8'h11);
    send_rx(8'h22);
    er = exp_res.pop_front();
    n_checks++; if ({result_valid, result} !== {1'b1, er}) begin
      n_fail++; $display("FAIL ready_low_result: got valid=%b %h expected valid=1 %h", result_valid, result, er); end
  endtask

  task automatic test_timeout;
    bit ok, early;
    int cnt;
    tx_bytes.delete(); tx_cycles.delete();
    do_start(16'h0102);
    wait_tx(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_tx_count: got %0d frames expected 2", tx_bytes.size()); end
    repeat (120) @(negedge clk);
    send_rx(8'hFF);
    cnt = 2;
    early = 1'b0;
    while (cnt < 300 && timeout_err !== 1'b1) begin
      @(negedge clk);
      cnt++;
      if (result_valid !== 1'b0) early = 1'b1;
    end
    // cnt counts negedges since the one before the byte-sampling edge
    n_checks++; if (cnt - 1 != TMO) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles expected %0d", cnt - 1, TMO); end
    n_checks++; if (early) begin n_fail++; $display("FAIL timeout_no_valid: got result_valid=1 expected 0"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b expected 0", busy); end
    n_checks++; if (result !== 16'h22FF) begin n_fail++; $display("FAIL timeout_partial: got %h expected 22ff", result); end
    @(negedge clk);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b expected 0", timeout_err); end
  endtask

  task automatic test_rx_level;
    bit ok;
    logic [15:0] er;
    tx_bytes.delete(); tx_cycles.delete();
    exp_res.push_back(16'h3412);
    do_start(16'h0505);
    wait_tx(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rx_level_tx_count: got %0d frames expected 2", tx_bytes.size()); end
    repeat (50) @(negedge clk);
    uart_received_data = 8'h77;
    uart_rx_valid = 1'b1;
    repeat (70) @(negedge clk);
    uart_rx_valid = 1'b0;
    @(negedge clk);
    send_rx(8'h12);
    n_checks++; if ({result_valid, busy} !== 2'b01) begin
      n_fail++; $display("FAIL rx_level_held: got valid=%b busy=%b expected valid=0 busy=1", result_valid, busy); end
    send_rx(8'h34);
    er = exp_res.pop_front();
    n_checks++; if ({result_valid, result} !== {1'b1, er}) begin
      n_fail++; $display("FAIL rx_level_result: got valid=%b %h expected valid=1 %h", result_valid, result, er); end
  endtask

  task automatic test_ignored;
    bit ok;
    logic [7:0] eb, gb;
    logic [15:0] er;
    tx_bytes.delete(); tx_cycles.delete();
    exp_tx.push_back(8'hB2); exp_tx.push_back(8'hA1);
    exp_res.push_back(16'hA55A);
    do_start(16'hA1B2);
    wait_tx(1, ok);
    repeat (20) @(negedge clk);
    op_ba = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_rx(8'h99);
    op_ba = 16'h0000;
    wait_tx(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ignored_tx_count: got %0d frames expected 2", tx_bytes.size()); end
    while (exp_tx.size() > 0) begin
      eb = exp_tx.pop_front();
      gb = (tx_bytes.size() > 0) ? tx_bytes.pop_front() : 8'hxx;
      n_checks++; if (gb !== eb) begin n_fail++; $display("FAIL ignored_frame: got %h expected %h", gb, eb); end
    end
    repeat (120) @(negedge clk);
    send_rx(8'h5A);
    send_rx(8'hA5);
    er = exp_res.pop_front();
    n_checks++; if ({result_valid, result} !== {1'b1, er}) begin
      n_fail++; $display("FAIL ignored_result: got valid=%b %h expected valid=1 %h", result_valid, result, er); end
    repeat (5) @(negedge clk);
    n_checks++; if (tx_bytes.size() != 0) begin n_fail++; $display("FAIL ignored_no_extra_tx: got %0d frames expected 0", tx_bytes.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok, seen;
    logic [7:0] eb, gb;
    logic [15:0] er;
    tx_bytes.delete(); tx_cycles.delete();
    do_start(16'h1234);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL reset_mid_tx_start: got 0 expected 1"); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++; if ({uart_tx_start, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_ctrl: got start=%b busy=%b expected 0 0", uart_tx_start, busy); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_result: got %h expected 0000", result); end
    repeat (10) @(negedge clk);
    n_checks++; if (tx_bytes.size() != 0) begin n_fail++; $display("FAIL reset_mid_abandon: got %0d frames expected 0", tx_bytes.size()); end
    exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF);
    exp_res.push_back(16'hFE01);
    do_start(16'hFFFF);
    wait_tx(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL reset_mid_tx_count: got %0d frames expected 2", tx_bytes.size()); end
    while (exp_tx.size() > 0) begin
      eb = exp_tx.pop_front();
      gb = (tx_bytes.size() > 0) ? tx_bytes.pop_front() : 8'hxx;
      n_checks++; if (gb !== eb) begin n_fail++; $display("FAIL reset_mid_frame: got %h expected %h", gb, eb); end
    end
    repeat (120) @(negedge clk);
    send_rx(8'h01);
    send_rx(8'hFE);
    er = exp_res.pop_front();
    n_checks++; if ({result_valid, result} !== {1'b1, er}) begin
      n_fail++; $display("FAIL reset_mid_result_fresh: got valid=%b %h expected valid=1 %h", result_valid, result, er); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_low();
    test_timeout();
    test_rx_level();
    test_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_host_uart_initiator.md
Name: mul_host_uart_initiator

Overview:
- Host-side end of the multiplier UART link. Serializes an operand pair into byte frames toward the multiplier core, then collects the product frames it returns and presents the assembled product.
- Sits between a byte-level UART transmit/receive block (tx_start/ready and rx_valid handshakes) and a host or test sequencer. Used for on-chip self-test and FPGA loopback of the multiplier core.

Parameters:
- N, 16, total operand-pair width in bits; must be a multiple of 8; sent as N/8 frames.
- RESULT_BYTES, 2, number of product frames expected back.
- GAP_CYCLES, 100, idle clocks inserted after each transmitted frame, before the next frame or the receive phase.
- TIMEOUT_CYCLES, 1000000, maximum clocks spent in the receive phase before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- op_ba  in  N  operand pair; bits [7:0] are A and go out as frame 0; bits [15:8] are B and go out as frame 1.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- uart_tx_start  out  1  byte-send request to the UART transmitter.
- uart_transmit_data  out  8  byte to send.
- uart_tx_ready  in  1  UART transmitter idle.
- uart_received_data  in  8  received byte; valid while uart_rx_valid is high.
- uart_rx_valid  in  1  received-byte flag; a new byte is marked by a rising edge.
- result  out  8*RESULT_BYTES  assembled product; frame 0 is the least significant byte.
- result_valid  out  1  one-cycle pulse when result is updated.
- timeout_err  out  1  one-cycle pulse when the receive phase is aborted.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low: when reset is low at a rising clk edge, the block enters IDLE.
- Reset values: busy=0, uart_tx_start=0, uart_transmit_data=0, result=0, result_valid=0, timeout_err=0. All counters and the rx edge register are cleared.
- rx edge register: captures uart_rx_valid every cycle in every state, so a level that is already high never counts as a new byte.
- IDLE: on start=1, latch op_ba into a shadow register, clear the frame counter, go to TX_REQ.
- TX_REQ: when uart_tx_ready=1, drive uart_tx_start=1 and uart_transmit_data = shadow[8*frame +: 8], go to TX_ACK.
- TX_ACK: hold start and data until uart_tx_ready falls (byte accepted). On the fall, drop uart_tx_start and go to TX_DONE.
- TX_DONE: wait until uart_tx_ready=1 again, then go to TX_GAP.
- TX_GAP: count GAP_CYCLES clocks. Then:
  - if frame == N/8-1, clear the frame counter and timeout counter and go to RX_WAIT;
  - otherwise increment frame and go to TX_REQ.
- RX_WAIT: on a rising edge of uart_rx_valid, write uart_received_data into result byte lane [frame], reset the timeout counter and increment frame.
  - After lane RESULT_BYTES-1 is written, go to DONE.
  - The timeout counter increments every cycle. On reaching TIMEOUT_CYCLES-1, pulse timeout_err, keep partially written lanes, and return to IDLE.
- DONE: pulse result_valid for exactly one cycle, return to IDLE.
- Latency: start to first uart_tx_start is 2 cycles if uart_tx_ready is already high. Last rx edge to result_valid is 2 cycles.
- Ignored events:
  - start is ignored while busy; op_ba changes after latching have no effect.
  - rx edges during the TX states are discarded and not buffered.
  - A stray rx edge in IDLE is ignored.
- Timeout versus byte: if an rx edge and the timeout terminal count coincide, the byte wins and the timeout counter resets.
- Frame counter width: clog2(max(N/8, RESULT_BYTES)), minimum 1 bit. It never exceeds its terminal value.
- Reset mid-transfer: uart_tx_start drops on the next edge, the phase is abandoned, and result reverts to 0.
- The unreachable state encoding returns to IDLE.

Test Plan:
- op_ba=16'h0B0C, start pulse, UART model echoes 0x84 then 0x00 -> frames sent in order 0x0C then 0x0B, each separated by at least GAP_CYCLES idle clocks; result=16'h0084; single result_valid pulse; busy falls the cycle after.
- uart_tx_ready held low for 50 cycles after start -> uart_tx_start stays 0 until ready rises; data is stable from start assertion until ready falls.
- Reply of only one byte 0xFF with TIMEOUT_CYCLES=200 -> timeout_err pulses exactly 200 cycles after that byte; result_valid never pulses; block returns to IDLE; a next start works normally.
- uart_rx_valid held high when RX_WAIT is entered, then a new byte 0x12 arrives -> the held level is not counted; only the later rising edge is captured.
- Second start pulse and rx edges issued during TX_GAP -> both ignored; frame order and final result are unchanged.
- reset low for one cycle during TX_ACK -> next cycle uart_tx_start=0, busy=0, result=0; a fresh transaction with op_ba=16'hFFFF and reply 0x01, 0xFE gives result=16'hFE01.
